// File: rtl/sensor_protocol_pkg.sv
// Shared PC <-> sensor protocol constants: command/response codes, continuous-mode
// encodings, controller FSM states and the received-command record.
package sensor_protocol_pkg;

    localparam logic [7:0] CMD_STATUS    = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
    localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
    localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

    localparam logic [7:0] RSP_OK        = 8'h07;
    localparam logic [7:0] RSP_HUM       = 8'h08;
    localparam logic [7:0] RSP_TEMP      = 8'h09;
    localparam logic [7:0] RSP_STOP_TEMP = 8'h0A;
    localparam logic [7:0] RSP_STOP_HUM  = 8'h0B;
    localparam logic [7:0] RSP_ERR       = 8'h1F;
    localparam logic [7:0] RSP_BAD_CMD   = 8'hEF;
    localparam logic [7:0] RSP_BAD_ADDR  = 8'hEE;

    localparam logic [1:0] CONT_OFF  = 2'b00;
    localparam logic [1:0] CONT_TEMP = 2'b01;
    localparam logic [1:0] CONT_HUM  = 2'b10;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_DECODE       = 3'd1;
    localparam state_t ST_SENSOR_START = 3'd2;
    localparam state_t ST_SENSOR_WAIT  = 3'd3;
    localparam state_t ST_LOAD0        = 3'd4;
    localparam state_t ST_TX0          = 3'd5;
    localparam state_t ST_LOAD1        = 3'd6;
    localparam state_t ST_TX1          = 3'd7;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
    } cmd_t;

    // Response code for a successful read issued by one of the read commands.
    function automatic logic [7:0] read_code(input logic [7:0] cmd);
        case (cmd)
            CMD_TEMP, CMD_CONT_TEMP: return RSP_TEMP;
            CMD_HUM, CMD_CONT_HUM:   return RSP_HUM;
            default:                 return RSP_OK;
        endcase
    endfunction

endpackage

// File: rtl/periodic_tick.sv
// Down-counter emitting a one-cycle tick every PERIOD cycles while enabled;
// reloads whenever disabled or cleared.
module periodic_tick #(
    parameter int unsigned PERIOD = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!enable || clear || count_q == '0) begin
            count_d = RELOAD;
        end else begin
            count_d = count_q - CW'(1);
        end
    end

    assign tick = enable && (count_q == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sensor_command_controller.sv
// Sequences two-byte PC commands into DHT11 reads and two-byte UART responses,
// with a one-deep pending command buffer and periodic continuous-mode reads.
module sensor_command_controller
    import sensor_protocol_pkg::*;
#(
    parameter int unsigned SENSOR_COUNT   = 1,
    parameter int unsigned CONT_PERIOD    = 100_000_000,
    parameter int unsigned SENSOR_TIMEOUT = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_command,
    input  logic [7:0] rx_address,
    output logic       sensor_start,
    input  logic       sensor_done,
    input  logic       sensor_error,
    input  logic [7:0] sensor_humidity,
    input  logic [7:0] sensor_temperature,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic [1:0] cont_mode,
    output logic       cmd_overflow
);

    localparam int unsigned TW = (SENSOR_TIMEOUT > 1) ? $clog2(SENSOR_TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    cmd_t          cur_q, cur_d;
    cmd_t          buf_q, buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic          tick_pend_q, tick_pend_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rsp_code_q, rsp_code_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          sensor_start_q, sensor_start_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [1:0]    cont_mode_q, cont_mode_d;
    logic          overflow_q, overflow_d;

    cmd_t rx_cmd;
    logic tick;
    logic tick_taken;

    assign rx_cmd = '{cmd: rx_command, addr: rx_address};

    periodic_tick #(
        .PERIOD(CONT_PERIOD)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(cont_mode_q != CONT_OFF),
        .clear (cont_mode_d != cont_mode_q),
        .tick  (tick)
    );

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        buf_d          = buf_q;
        buf_valid_d    = buf_valid_q;
        tick_pend_d    = tick_pend_q;
        tick_taken     = 1'b0;
        tmo_d          = tmo_q;
        rsp_code_d     = rsp_code_q;
        rsp_data_d     = rsp_data_q;
        sensor_start_d = 1'b0;
        tx_start_d     = 1'b0;
        tx_byte_d      = tx_byte_q;
        cont_mode_d    = cont_mode_q;
        overflow_d     = overflow_q;

        if (rx_done && state_q != ST_IDLE) begin
            if (buf_valid_q) begin
                overflow_d = 1'b1;
            end else begin
                buf_d       = rx_cmd;
                buf_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A new arrival while the buffer drains refills it in the same cycle.
                if (buf_valid_q) begin
                    cur_d   = buf_q;
                    state_d = ST_DECODE;
                    if (rx_done) begin
                        buf_d = rx_cmd;
                    end else begin
                        buf_valid_d = 1'b0;
                    end
                end else if (rx_done) begin
                    cur_d   = rx_cmd;
                    state_d = ST_DECODE;
                end else if (tick_pend_q || tick) begin
                    cur_d.cmd   = (cont_mode_q == CONT_TEMP) ? CMD_TEMP : CMD_HUM;
                    cur_d.addr  = '0;
                    tick_pend_d = 1'b0;
                    tick_taken  = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_LOAD0;
                if ({24'd0, cur_q.addr} >= SENSOR_COUNT) begin
                    rsp_code_d = RSP_BAD_ADDR;
                    rsp_data_d = cur_q.addr;
                end else if (cur_q.cmd > CMD_STOP_HUM) begin
                    rsp_code_d = RSP_BAD_CMD;
                    rsp_data_d = cur_q.cmd;
                end else if (cur_q.cmd == CMD_STOP_TEMP) begin
                    rsp_code_d = RSP_STOP_TEMP;
                    rsp_data_d = '0;
                    if (cont_mode_q == CONT_TEMP) cont_mode_d = CONT_OFF;
                end else if (cur_q.cmd == CMD_STOP_HUM) begin
                    rsp_code_d = RSP_STOP_HUM;
                    rsp_data_d = '0;
                    if (cont_mode_q == CONT_HUM) cont_mode_d = CONT_OFF;
                end else begin
                    state_d        = ST_SENSOR_START;
                    sensor_start_d = 1'b1;
                end
            end
            ST_SENSOR_START: begin
                tmo_d   = '0;
                state_d = ST_SENSOR_WAIT;
            end
            ST_SENSOR_WAIT: begin
                if (sensor_done) begin
                    state_d = ST_LOAD0;
                    if (sensor_error) begin
                        rsp_code_d = RSP_ERR;
                        rsp_data_d = '0;
                    end else begin
                        rsp_code_d = read_code(cur_q.cmd);
                        case (cur_q.cmd)
                            CMD_TEMP, CMD_CONT_TEMP: rsp_data_d = sensor_temperature;
                            CMD_HUM, CMD_CONT_HUM:   rsp_data_d = sensor_humidity;
                            default:                 rsp_data_d = '0;
                        endcase
                        if (cur_q.cmd == CMD_CONT_TEMP) cont_mode_d = CONT_TEMP;
                        if (cur_q.cmd == CMD_CONT_HUM)  cont_mode_d = CONT_HUM;
                    end
                end else if (tmo_q == TW'(SENSOR_TIMEOUT - 1)) begin
                    state_d    = ST_LOAD0;
                    rsp_code_d = RSP_ERR;
                    rsp_data_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_LOAD0: begin
                tx_byte_d  = rsp_code_q;
                tx_start_d = 1'b1;
                state_d    = ST_TX0;
            end
            ST_TX0: begin
                if (tx_done) state_d = ST_LOAD1;
            end
            ST_LOAD1: begin
                tx_byte_d  = rsp_data_q;
                tx_start_d = 1'b1;
                state_d    = ST_TX1;
            end
            ST_TX1: begin
                if (tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick coinciding with a mode change belongs to the old period and is dropped.
        if (tick && !tick_taken && cont_mode_d == cont_mode_q) tick_pend_d = 1'b1;
        if (cont_mode_d == CONT_OFF) tick_pend_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            buf_q          <= '0;
            buf_valid_q    <= 1'b0;
            tick_pend_q    <= 1'b0;
            tmo_q          <= '0;
            rsp_code_q     <= '0;
            rsp_data_q     <= '0;
            sensor_start_q <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_byte_q      <= '0;
            cont_mode_q    <= CONT_OFF;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            buf_q          <= buf_d;
            buf_valid_q    <= buf_valid_d;
            tick_pend_q    <= tick_pend_d;
            tmo_q          <= tmo_d;
            rsp_code_q     <= rsp_code_d;
            rsp_data_q     <= rsp_data_d;
            sensor_start_q <= sensor_start_d;
            tx_start_q     <= tx_start_d;
            tx_byte_q      <= tx_byte_d;
            cont_mode_q    <= cont_mode_d;
            overflow_q     <= overflow_d;
        end
    end

    assign sensor_start = sensor_start_q;
    assign tx_start     = tx_start_q;
    assign tx_byte      = tx_byte_q;
    assign cont_mode    = cont_mode_q;
    assign cmd_overflow = overflow_q;

endmodule

// File: tb/tb_sensor_command_controller.sv
// Bench for sensor_command_controller: vector table plus sequences for continuous
// mode, the pending buffer/overflow and reset during transmission.
module tb_sensor_command_controller;

    localparam int unsigned T_PERIOD = 1000;
    localparam int unsigned T_TMO    = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_command = '0;
    logic [7:0] rx_address = '0;
    logic       sensor_start;
    logic       sensor_done = 1'b0;
    logic       sensor_error = 1'b0;
    logic [7:0] sensor_humidity = '0;
    logic [7:0] sensor_temperature = '0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done = 1'b0;
    logic [1:0] cont_mode;
    logic       cmd_overflow;

    sensor_command_controller #(
        .SENSOR_COUNT  (1),
        .CONT_PERIOD   (T_PERIOD),
        .SENSOR_TIMEOUT(T_TMO)
    ) dut (
        .clock             (clk),
        .reset             (reset),
        .rx_done           (rx_done),
        .rx_command        (rx_command),
        .rx_address        (rx_address),
        .sensor_start      (sensor_start),
        .sensor_done       (sensor_done),
        .sensor_error      (sensor_error),
        .sensor_humidity   (sensor_humidity),
        .sensor_temperature(sensor_temperature),
        .tx_start          (tx_start),
        .tx_byte           (tx_byte),
        .tx_done           (tx_done),
        .cont_mode         (cont_mode),
        .cmd_overflow      (cmd_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Logged times are the clock edge at which the signal is sampled.
    int         start_log[$];
    int         done_log[$];
    int         tx_log[$];
    int         txd_log[$];
    logic [7:0] got_q[$];

    bit hold_done = 1'b0;
    int sd_cnt = 0;
    always @(negedge clk) begin
        sensor_done = 1'b0;
        if (sd_cnt > 0) begin
            sd_cnt--;
            if (sd_cnt == 0) begin
                sensor_done = 1'b1;
                done_log.push_back(cyc + 1);
            end
        end
        if (sensor_start) begin
            start_log.push_back(cyc + 1);
            if (!hold_done) sd_cnt = 5;
        end
    end

    int txd_cnt = 0;
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (txd_cnt > 0) begin
            txd_cnt--;
            if (txd_cnt == 0) begin
                tx_done = 1'b1;
                txd_log.push_back(cyc + 1);
            end
        end
        if (tx_start) begin
            tx_log.push_back(cyc + 1);
            got_q.push_back(tx_byte);
            txd_cnt = 3;
        end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        bit         err;
        bit         hold;
        logic [7:0] t;
        logic [7:0] h;
        logic [7:0] code;
        logic [7:0] data;
        int         starts;
    } vec_t;

    vec_t       vecs[11];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         rd_idx = 0;
    int         rx_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] cmd, input logic [7:0] addr);
        @(negedge clk);
        rx_command = cmd;
        rx_address = addr;
        rx_done    = 1'b1;
        rx_cyc     = cyc + 1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 3000 && tx_log.size() < target; i++) @(negedge clk);
        if (tx_log.size() < target) check("tx_wait_timeout", tx_log.size(), target);
        repeat (8) @(negedge clk);
    endtask

    task automatic drain();
        while (rd_idx < got_q.size()) begin
            if (exp_q.size() == 0) check("unexpected_tx_byte", int'(got_q[rd_idx]), 256);
            else check("tx_byte", int'(got_q[rd_idx]), int'(exp_q.pop_front()));
            rd_idx++;
        end
        check("missing_tx_bytes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, t0, k0;

        vecs[0]  = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'h09, 8'h19, 1};
        vecs[1]  = '{8'h02, 8'h05, 1'b0, 1'b0, 8'h19, 8'h3C, 8'hEE, 8'h05, 0};
        vecs[2]  = '{8'h09, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'hEF, 8'h09, 0};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h19, 8'h3C, 8'h1F, 8'h00, 1};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'h07, 8'h00, 1};
        vecs[5]  = '{8'h02, 8'h00, 1'b0, 1'b0, 8'h22, 8'h3C, 8'h08, 8'h3C, 1};
        vecs[6]  = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h19, 8'h3C, 8'h1F, 8'h00, 1};
        vecs[7]  = '{8'h05, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'h0A, 8'h00, 0};
        vecs[8]  = '{8'h06, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'h0B, 8'h00, 0};
        vecs[9]  = '{8'h07, 8'h00, 1'b0, 1'b0, 8'h19, 8'h3C, 8'hEF, 8'h07, 0};
        vecs[10] = '{8'h09, 8'h01, 1'b0, 1'b0, 8'h19, 8'h3C, 8'hEE, 8'h01, 0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sensor_start", sensor_start, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_cont_mode", cont_mode, 0);
        check("rst_cmd_overflow", cmd_overflow, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            sensor_temperature = vecs[i].t;
            sensor_humidity    = vecs[i].h;
            sensor_error       = vecs[i].err;
            hold_done          = vecs[i].hold;
            s0 = start_log.size();
            d0 = done_log.size();
            t0 = tx_log.size();
            k0 = txd_log.size();
            push2(vecs[i].code, vecs[i].data);
            send(vecs[i].cmd, vecs[i].addr);
            wait_tx(t0 + 2);
            drain();
            check("sensor_starts", start_log.size() - s0, vecs[i].starts);
            check("cont_mode_idle", cont_mode, 0);
            if (tx_log.size() >= t0 + 2 && txd_log.size() > k0) begin
                check("tx1_after_tx_done", tx_log[t0+1] - txd_log[k0], 2);
                if (vecs[i].starts == 0) begin
                    check("noread_tx_latency", tx_log[t0] - rx_cyc, 3);
                end else if (start_log.size() > s0) begin
                    check("start_latency", start_log[s0] - rx_cyc, 2);
                    if (vecs[i].hold) check("timeout_cycles", tx_log[t0] - start_log[s0], T_TMO + 2);
                    else if (done_log.size() > d0) check("done_to_tx0", tx_log[t0] - done_log[d0], 2);
                end
            end
        end
        hold_done    = 1'b0;
        sensor_error = 1'b0;

        // Continuous humidity: one-shot response, two periodic reads, then stop.
        sensor_humidity = 8'h3C;
        s0 = start_log.size();
        d0 = done_log.size();
        t0 = tx_log.size();
        push2(8'h08, 8'h3C);
        send(8'h04, 8'h00);
        wait_tx(t0 + 2);
        drain();
        check("cont_mode_hum", cont_mode, 2);
        push2(8'h08, 8'h3C);
        push2(8'h08, 8'h3C);
        wait_tx(t0 + 6);
        drain();
        check("cont_reads", start_log.size() - s0, 3);
        if (start_log.size() >= s0 + 3 && done_log.size() > d0) begin
            check("first_tick_delay", start_log[s0+1] - done_log[d0], T_PERIOD + 2);
            check("tick_interval", start_log[s0+2] - start_log[s0+1], T_PERIOD);
        end
        s0 = start_log.size();
        t0 = tx_log.size();
        push2(8'h0B, 8'h00);
        send(8'h06, 8'h00);
        wait_tx(t0 + 2);
        drain();
        check("cont_mode_off", cont_mode, 0);
        repeat (2500) @(negedge clk);
        check("reads_after_stop", start_log.size() - s0, 0);
        check("tx_after_stop", tx_log.size() - t0, 2);
        drain();

        // Three arrivals in one transaction: second buffered, third dropped.
        sensor_temperature = 8'h19;
        check("overflow_before", cmd_overflow, 0);
        s0 = start_log.size();
        t0 = tx_log.size();
        push2(8'h09, 8'h19);
        push2(8'h08, 8'h3C);
        send(8'h01, 8'h00);
        send(8'h02, 8'h00);
        send(8'h09, 8'h00);
        wait_tx(t0 + 4);
        repeat (20) @(negedge clk);
        drain();
        check("overflow_after", cmd_overflow, 1);
        check("buffered_reads", start_log.size() - s0, 2);
        check("buffered_tx_bytes", tx_log.size() - t0, 4);

        // Reset while the first response byte is in flight.
        t0 = tx_log.size();
        exp_q.push_back(8'hEF);
        send(8'h09, 8'h00);
        for (int i = 0; i < 100 && tx_log.size() == t0; i++) @(negedge clk);
        check("tx0_reached", tx_log.size() - t0, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_sensor_start", sensor_start, 0);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_byte", tx_byte, 0);
        check("mid_rst_cont_mode", cont_mode, 0);
        check("mid_rst_cmd_overflow", cmd_overflow, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no_partial_response", tx_log.size() - t0, 1);
        drain();
        t0 = tx_log.size();
        push2(8'h09, 8'h19);
        send(8'h01, 8'h00);
        wait_tx(t0 + 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_command_controller.md
# sensor_command_controller

Sequences the FPGA's PC-to-sensor request path. Takes each two-byte command received by `uart_rx` (command, sensor address), runs a DHT11 read through the sensor interface, and returns a two-byte response (code, data) through `uart_tx`. Also runs the periodic continuous-monitoring mode. It replaces the direct `uart_rx` → display path in the top module.

## Interface
Parameters:
- `SENSOR_COUNT`, default 1: number of valid sensor addresses (0..SENSOR_COUNT-1).
- `CONT_PERIOD`, default 100_000_000: clock cycles between continuous-mode reads (2 s at 50 MHz).
- `SENSOR_TIMEOUT`, default 5_000_000: cycles allowed from `sensor_start` to `sensor_done`.

Ports:
- `clock` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-low reset.
- `rx_done` in 1: one-cycle pulse; both command bytes are valid.
- `rx_command` in 8: first received byte (command).
- `rx_address` in 8: second received byte (sensor address).
- `sensor_start` out 1: one-cycle pulse that starts a DHT11 read.
- `sensor_done` in 1: one-cycle pulse; the read has finished.
- `sensor_error` in 1: valid with `sensor_done`; checksum or protocol failure.
- `sensor_humidity` in 8: integer humidity; valid with `sensor_done`.
- `sensor_temperature` in 8: integer temperature; valid with `sensor_done`.
- `tx_start` out 1: one-cycle pulse that starts transmission of `tx_byte`.
- `tx_byte` out 8: byte to transmit; held stable until `tx_done`.
- `tx_done` in 1: one-cycle pulse; the byte has been sent.
- `cont_mode` out 2: continuous-mode state. 00 off, 01 temperature, 10 humidity.
- `cmd_overflow` out 1: sticky. Set when a command is dropped; cleared only by reset.

## Operation
- Commands: 0x00 sensor status, 0x01 temperature, 0x02 humidity, 0x03 start continuous temperature, 0x04 start continuous humidity, 0x05 stop continuous temperature, 0x06 stop continuous humidity.
- Response codes:
  - 0x07 sensor OK, data 0x00.
  - 0x08 humidity, data = humidity.
  - 0x09 temperature, data = temperature.
  - 0x0A continuous temperature stopped, data 0x00.
  - 0x0B continuous humidity stopped, data 0x00.
  - 0x1F sensor error, data 0x00.
  - 0xEF invalid command, data = `rx_command`.
  - 0xEE invalid address, data = `rx_address`.
- Check order: invalid address first (address >= SENSOR_COUNT), then invalid command (value > 0x06).
  - Invalid address or invalid command: no sensor read; respond immediately.
- Commands 0x00–0x04 perform a sensor read.
  - Sensor error or timeout: respond 0x1F.
  - 0x03 and 0x04 respond as one-shot 0x09 and 0x08, then set `cont_mode`.
  - Starting one continuous mode replaces the other.
- Commands 0x05 and 0x06 clear `cont_mode` only if the matching mode is active. They send 0x0A/0x0B and no sensor read in every case.
- Continuous mode: the period counter runs while `cont_mode` != 00 and restarts at each period tick and on every mode change.
  - A tick issues a read plus a 0x09 or 0x08 response, or 0x1F on error.
- Pending command buffer, one deep: a `rx_done` that arrives when the controller is not in IDLE is latched there.
  - A second arrival while the buffer is full is dropped and sets `cmd_overflow`; the earlier buffered command is kept.
- Priority in IDLE: buffered command, then new `rx_done`, then continuous tick.
  - A tick that fires while busy is held as a flag and serviced in IDLE.
  - A held tick is discarded if the mode is turned off before it is serviced.
- FSM states:
  - IDLE → DECODE.
  - DECODE → SENSOR_START, or → LOAD0 when no read is needed.
  - SENSOR_START → SENSOR_WAIT.
  - SENSOR_WAIT → LOAD0 on `sensor_done` or on timeout.
  - LOAD0 → TX0.
  - TX0 → LOAD1 on `tx_done`.
  - LOAD1 → TX1.
  - TX1 → IDLE on `tx_done`.
- A `sensor_done` pulse received outside SENSOR_WAIT is ignored.

## Timing
- Reset (while `reset`=0 at a clock edge):
  - FSM to IDLE.
  - `sensor_start`=0, `tx_start`=0, `tx_byte`=0x00, `cont_mode`=00, `cmd_overflow`=0.
  - Pending buffer, tick flag and counters cleared.
  - Reset mid-transaction abandons the transaction silently; no partial response is sent.
- `rx_done` in IDLE at edge N: DECODE at N+1.
  - Read command: `sensor_start` high during N+2.
  - Command with no read: `tx_start` high during N+3.
- `sensor_done` at edge M: `tx_start` for byte 0 high during M+2.
- After byte 0 `tx_done` at edge K: `tx_start` for byte 1 high during K+2.
- Timeout: SENSOR_WAIT exits after exactly SENSOR_TIMEOUT cycles without `sensor_done`.
- Response data captured at `sensor_done` and held until the transaction ends.

## Structure
- Shared package `sensor_protocol_pkg`: command codes, response codes, `cont_mode` encodings, FSM state enum. The same constants are reused by the PC software interface and the display decoder.
- One sub-module: `periodic_tick`, a down-counter that emits a one-cycle tick every CONT_PERIOD cycles while enabled and restarts on clear.

## Test plan
Run the bench with CONT_PERIOD=1000 and SENSOR_TIMEOUT=200.
- Command 0x01, address 0x00; sensor returns T=0x19, no error → TX 0x09 then 0x19; `sensor_start` exactly once.
- Command 0x02, address 0x05 → TX 0xEE then 0x05; no `sensor_start`.
- Command 0x09, address 0x00 → TX 0xEF then 0x09. Command 0x00 with `sensor_done` withheld → TX 0x1F then 0x00 after 200 cycles.
- Command 0x04 (H=0x3C):
  - TX 0x08/0x3C; `cont_mode`=10; repeat reads every 1000 cycles.
  - Then command 0x06 → TX 0x0B/0x00; `cont_mode`=00; no further reads.
- Three `rx_done` pulses inside one transaction:
  - The second is served next.
  - The third is dropped.
  - `cmd_overflow`=1.
- Assert reset while in TX0 → all outputs return to their reset values; the next command is processed normally.
